// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte-stream requesters share one UART transmitter.
// A grant is held for a whole packet, bounded by MAX_PKT_LEN, with an idle gap after it.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned MAX_PKT_LEN = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    input  logic [8*NUM_REQ-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]   req_last_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    output logic [7:0]           tx_byte_out,
    output logic                 tx_valid_out,
    input  logic                 tx_ready_in,
    output logic [NUM_REQ-1:0]   grant_out,
    output logic                 busy_out,
    output logic                 overrun_out
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [7:0] MaxLen = 8'(MAX_PKT_LEN);
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IdxW-1:0]    last_grant_q, last_grant_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
    logic               overrun_q, overrun_d;

    logic               pick_found;
    logic [IdxW-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               sel_last;
    logic [IdxW-1:0]    sel_idx;
    logic [7:0]         byte_cnt_inc;
    logic               tx_xfer;
    logic               end_pkt;

    // Round-robin search starting one past the requester served last.
    always_comb begin
        int unsigned cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_grant_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_found && req_valid_in[IdxW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(cand);
            end
        end
    end

    assign pick_onehot = OneHot0 << pick_idx;

    // Granted requester is connected straight through to the transmitter while sending.
    always_comb begin
        tx_valid_out  = 1'b0;
        tx_byte_out   = '0;
        req_ready_out = '0;
        sel_last      = 1'b0;
        sel_idx       = '0;
        if (state_q == StSend) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i]) begin
                    tx_valid_out     = req_valid_in[i];
                    tx_byte_out      = req_data_in[8*i +: 8];
                    req_ready_out[i] = tx_ready_in;
                    sel_last         = req_last_in[i];
                    sel_idx          = IdxW'(i);
                end
            end
        end
    end

    assign tx_xfer      = tx_valid_out && tx_ready_in;
    assign byte_cnt_inc = byte_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        overrun_d    = 1'b0;
        end_pkt      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d    = pick_onehot;
                    byte_cnt_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (tx_xfer) begin
                    if (sel_last) begin
                        end_pkt = 1'b1;
                    end else if (byte_cnt_inc == MaxLen) begin
                        end_pkt   = 1'b1;
                        overrun_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_inc;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        if (end_pkt) begin
            grant_d      = '0;
            last_grant_d = sel_idx;
            gap_cnt_d    = '0;
            state_d      = (GAP_CYCLES > 0) ? StGap : StIdle;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            overrun_q    <= overrun_d;
        end
    end

    assign grant_out   = grant_q;
    assign busy_out    = (state_q != StIdle);
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one default instance and one with GAP_CYCLES=0.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rv, rl, rdy, grant;
    logic [31:0] rd;
    logic [7:0]  tx_byte;
    logic        tx_valid, txr, busy, overrun;

    logic [3:0]  rv0, rl0, rdy0, grant0;
    logic [31:0] rd0;
    logic [7:0]  tx_byte0;
    logic        tx_valid0, txr0, busy0, overrun0;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16), .MAX_PKT_LEN(64)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(rv), .req_data_in(rd),
        .req_last_in(rl), .req_ready_out(rdy), .tx_byte_out(tx_byte),
        .tx_valid_out(tx_valid), .tx_ready_in(txr), .grant_out(grant),
        .busy_out(busy), .overrun_out(overrun)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .MAX_PKT_LEN(64)) dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(rv0), .req_data_in(rd0),
        .req_last_in(rl0), .req_ready_out(rdy0), .tx_byte_out(tx_byte0),
        .tx_valid_out(tx_valid0), .tx_ready_in(txr0), .grant_out(grant0),
        .busy_out(busy0), .overrun_out(overrun0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive requester idx, already granted, until its grant drops; byte k carries value k.
    task automatic stream(input int idx, input int last_at, output int xf, output int ov,
                          output int ov_at, output int berr);
        int n;
        bit moved;
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        xf = 0; ov = 0; ov_at = -1; berr = 0; n = 0;
        while (grant == oh && n < 200) begin
            rd[8*idx +: 8] = 8'(xf);
            rl[idx] = (last_at != 0) && (xf == last_at - 1);
            #1;
            if (tx_valid && tx_byte !== 8'(xf)) berr++;
            moved = tx_valid && txr;
            tick();
            n++;
            if (moved) xf++;
            if (overrun) begin
                ov++;
                ov_at = xf;
            end
        end
        rl[idx] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n, xf, ov, ov_at, berr;
        rst_n = 1'b0; rv = '0; rl = '0; rd = '0; txr = 1'b0;
        rv0 = '0; rl0 = '0; rd0 = '0; txr0 = 1'b0;

        tick(); tick();
        chk("rst_grant", {28'd0, grant}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_txvalid", {31'd0, tx_valid}, 32'h0);
        chk("rst_ready", {28'd0, rdy}, 32'h0);
        chk("rst_overrun", {31'd0, overrun}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Requester 1: three-byte packet with a stalling transmitter.
        rv = 4'b0010; rd[15:8] = 8'hA1; txr = 1'b1;
        #1;
        chk("p1_idle_txvalid", {31'd0, tx_valid}, 32'h0);
        tick();
        chk("p1_grant_a", {28'd0, grant}, 32'h2);
        chk("p1_byte_a1", {24'd0, tx_byte}, 32'hA1);
        chk("p1_ready_a", {28'd0, rdy}, 32'h2);
        chk("p1_busy", {31'd0, busy}, 32'h1);
        tick();
        rd[15:8] = 8'hA2; txr = 1'b0;
        #1;
        chk("p1_byte_a2", {24'd0, tx_byte}, 32'hA2);
        chk("p1_ready_stall", {28'd0, rdy}, 32'h0);
        tick();
        txr = 1'b1;
        #1;
        chk("p1_grant_b", {28'd0, grant}, 32'h2);
        chk("p1_ready_b", {28'd0, rdy}, 32'h2);
        tick();
        rd[15:8] = 8'hA3; rl = 4'b0010;
        #1;
        chk("p1_byte_a3", {24'd0, tx_byte}, 32'hA3);
        chk("p1_grant_c", {28'd0, grant}, 32'h2);
        tick();
        rv = '0; rl = '0;
        #1;
        chk("p1_gap_grant", {28'd0, grant}, 32'h0);
        chk("p1_gap_txvalid", {31'd0, tx_valid}, 32'h0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("p1_gap_len", n, 32'd16);

        // All four requesters, one-byte packets, right after reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rv = 4'b1111; rl = 4'b1111; rd = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (grant == 4'b0000 && n < 60) begin
                tick();
                n++;
            end
            chk("rr_grant", {28'd0, grant}, 32'd1 << (k % 4));
            chk("rr_byte", {24'd0, tx_byte}, 32'h10 + (k % 4));
            tick();
            chk("rr_gap_grant", {28'd0, grant}, 32'h0);
            chk("rr_gap_busy", {31'd0, busy}, 32'h1);
        end
        rv = '0; rl = '0;
        wait_idle("rr_idle");

        // Requester 2 streams without last; requester 3 is pending.
        rv = 4'b1100; rd = 32'h3300_0000;
        tick();
        chk("ov_grant", {28'd0, grant}, 32'h4);
        chk("ov_ready_other", {28'd0, rdy}, 32'h4);
        stream(2, 0, xf, ov, ov_at, berr);
        chk("ov_xfers", xf, 32'd64);
        chk("ov_pulses", ov, 32'd1);
        chk("ov_at", ov_at, 32'd64);
        chk("ov_bytes", berr, 32'd0);
        tick();
        chk("ov_pulse_end", {31'd0, overrun}, 32'h0);
        n = 0;
        while (grant == 4'b0000 && n < 60) begin
            tick();
            n++;
        end
        chk("ov_next_grant", {28'd0, grant}, 32'h8);
        rl = 4'b1000;
        tick();
        rv = '0; rl = '0;
        wait_idle("ov_idle");

        // Requester 0: 64th byte carries last, so no overrun.
        rv = 4'b0001;
        tick();
        chk("lm_grant", {28'd0, grant}, 32'h1);
        stream(0, 64, xf, ov, ov_at, berr);
        chk("lm_xfers", xf, 32'd64);
        chk("lm_pulses", ov, 32'd0);
        chk("lm_bytes", berr, 32'd0);
        chk("lm_gap_busy", {31'd0, busy}, 32'h1);
        rv = '0;
        wait_idle("lm_idle");

        // Reset mid-packet on byte 2 of 5, then requesters 0 and 3 compete.
        rv = 4'b0100; rd[23:16] = 8'h50;
        tick();
        chk("mr_grant", {28'd0, grant}, 32'h4);
        tick();
        rd[23:16] = 8'h51;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_grant_clr", {28'd0, grant}, 32'h0);
        chk("mr_txvalid", {31'd0, tx_valid}, 32'h0);
        chk("mr_busy", {31'd0, busy}, 32'h0);
        chk("mr_ready", {28'd0, rdy}, 32'h0);
        rv = 4'b1001;
        tick();
        chk("mr_prio0", {28'd0, grant}, 32'h1);
        rl = 4'b0001;
        tick();
        rv = '0; rl = '0;
        wait_idle("mr_idle");

        // Zero-gap instance: back-to-back packets from requesters 0 and 1.
        rv0 = 4'b0011; rl0 = 4'b0011; rd0 = 32'h0000_B1B0; txr0 = 1'b1;
        tick();
        chk("g0_grant0", {28'd0, grant0}, 32'h1);
        chk("g0_byte0", {24'd0, tx_byte0}, 32'hB0);
        tick();
        n = 0;
        while (!tx_valid0 && n < 20) begin
            n++;
            tick();
        end
        chk("g0_idle_cycles", n, 32'd1);
        chk("g0_grant1", {28'd0, grant0}, 32'h2);
        chk("g0_byte1", {24'd0, tx_byte0}, 32'hB1);
        tick();
        rv0 = '0; rl0 = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
